ultra_scan_sched: RTL and testbench

ULTRA_SCAN_SCHED -- requirements
Module: ultra_scan_sched

---
 rtl/ultra_scan_sched.sv | 168 ++++++++++++++++
 tb/tb_ultra_scan_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ultra_scan_sched.sv
// Round-robin ultrasonic sensor scheduler: triggers one sensor at a time,
// times its echo, reports width/timeout and keeps per-sensor near flags.
module ultra_scan_sched #(
  parameter int N_SENS         = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int GUARD_CYCLES   = 500000,
  parameter int THRESH_CYCLES  = 58823
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_SENS-1:0] echo,
  output logic [N_SENS-1:0] trigger,
  output logic              meas_valid,
  output logic [2:0]        meas_id,
  output logic [21:0]       meas_width,
  output logic              meas_timeout,
  output logic [N_SENS-1:0] near,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  // Handshake: meas_valid is a one-cycle strobe with no back-pressure; meas_id,
  // meas_width, meas_timeout and near are all valid in that same cycle.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    GUARD     = 3'd4
  } state_t;

  localparam logic [21:0] TRIG_LAST  = 22'(TRIG_CYCLES - 1);
  localparam logic [21:0] GUARD_LAST = 22'(GUARD_CYCLES - 1);
  localparam logic [21:0] TMO        = 22'(TIMEOUT_CYCLES);
  localparam logic [21:0] THR        = 22'(THRESH_CYCLES);
  localparam logic [2:0]  PTR_LAST   = 3'(N_SENS - 1);

  state_t            state, state_d;
  logic [2:0]        ptr, ptr_d;
  logic [21:0]       cnt, cnt_d;
  logic [21:0]       tmo, tmo_d, tmo_inc;
  logic [21:0]       wid, wid_d;
  logic              rep, rep_tmo;
  logic [N_SENS-1:0] echo_s1, echo_s2;
  logic              echo_sel;

  always_comb begin
    echo_sel = 1'b0;
    trigger  = '0;
    for (int i = 0; i < N_SENS; i++) begin
      if (ptr == 3'(i)) begin
        echo_sel   = echo_s2[i];
        trigger[i] = (state == TRIG);
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign tmo_inc   = tmo + 22'd1;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    tmo_d   = tmo;
    wid_d   = wid;
    rep     = 1'b0;
    rep_tmo = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt + 22'd1;
        end
      end
      WAIT_RISE: begin
        tmo_d = tmo_inc;
        if (tmo_inc >= TMO) begin
          rep     = 1'b1;
          rep_tmo = 1'b1;
        end else if (echo_sel) begin
          // The rise cycle is itself a high cycle, so it is counted.
          state_d = MEASURE;
          wid_d   = 22'd1;
        end
      end
      MEASURE: begin
        tmo_d = tmo_inc;
        if (tmo_inc >= TMO) begin
          rep     = 1'b1;
          rep_tmo = 1'b1;
        end else if (!echo_sel) begin
          rep = 1'b1;
        end else if (wid < TMO) begin
          wid_d = wid + 22'd1;
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          cnt_d   = '0;
          ptr_d   = (ptr == PTR_LAST) ? 3'd0 : ptr + 3'd1;
          state_d = enable ? TRIG : IDLE;
        end else begin
          cnt_d = cnt + 22'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rep) begin
      state_d = GUARD;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      tmo     <= '0;
      wid     <= '0;
      echo_s1 <= '0;
      echo_s2 <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
      tmo     <= tmo_d;
      wid     <= wid_d;
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid   <= 1'b0;
      meas_id      <= '0;
      meas_width   <= '0;
      meas_timeout <= 1'b0;
      near         <= '0;
    end else begin
      meas_valid <= rep;
      if (rep) begin
        meas_id      <= ptr;
        meas_width   <= rep_tmo ? TMO : wid;
        meas_timeout <= rep_tmo;
        for (int i = 0; i < N_SENS; i++) begin
          if (ptr == 3'(i)) near[i] <= !rep_tmo && (wid <= THR);
        end
      end
    end
  end

endmodule

// File: tb/tb_ultra_scan_sched.sv
// Directed bench for ultra_scan_sched: an echo driver answers each trigger,
// a monitor pops expected results from a queue on every meas_valid.
module tb_ultra_scan_sched;

  localparam int W = 30;  // {id[2:0], width[21:0], timeout, near[3:0]}

  logic        clk, rst_n, enable;
  logic [3:0]  echo, trigger, near;
  logic        meas_valid, meas_timeout, busy;
  logic [2:0]  meas_id, state_dbg;
  logic [21:0] meas_width;

  logic [W-1:0] exp_q[$];
  int total, bad;

  ultra_scan_sched #(
    .N_SENS(4), .TRIG_CYCLES(4), .TIMEOUT_CYCLES(100),
    .GUARD_CYCLES(10), .THRESH_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo),
    .trigger(trigger), .meas_valid(meas_valid), .meas_id(meas_id),
    .meas_width(meas_width), .meas_timeout(meas_timeout), .near(near),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // driver tasks
  task automatic pulse(input int s, input int dly, input int wid);
    repeat (dly) @(negedge clk);
    echo[s] = 1'b1;
    repeat (wid) @(negedge clk);
    echo[s] = 1'b0;
  endtask

  // mode: 0 plain, 1 distractor pulses on other sensors, 2 check timeout latency,
  // 3 drop enable mid-measurement
  task automatic run_meas(input int id, input int dly, input int wid, input int mode,
                          input int exp_w, input bit exp_t, input logic [3:0] exp_n);
    int k;
    logic [3:0] oh;
    k = 0;
    while (trigger == 4'b0 && k < 400) begin @(negedge clk); k++; end
    if (trigger == 4'b0) begin
      chk("trig_wait_timeout", 32'(k), 32'(400 + 1));
      return;
    end
    oh = 4'b0001 << id;
    chk("trig_onehot", 32'(trigger), 32'(oh));
    k = 0;
    while (trigger != 4'b0 && k < 50) begin @(negedge clk); k++; end
    chk("trig_width", 32'(k), 32'd4);
    exp_q.push_back({3'(id), 22'(exp_w), exp_t, exp_n});
    if (wid > 0) begin
      fork
        begin
          automatic int s = id, d = dly, w = wid;
          pulse(s, d, w);
        end
      join_none
    end
    if (mode == 1) begin
      for (int j = 0; j < 4; j++) begin
        if (j != id) begin
          fork
            begin
              automatic int s = j;
              pulse(s, 1, 15);
            end
          join_none
        end
      end
    end
    if (mode == 2) begin
      k = 0;
      while (!meas_valid && k < 200) begin @(negedge clk); k++; end
      chk("timeout_latency", 32'(k), 32'd100);
    end
    if (mode == 3) begin
      repeat (15) @(negedge clk);
      enable = 1'b0;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: id=%0d width=%0d tmo=%0b near=%b, queue empty",
                 meas_id, meas_width, meas_timeout, near);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        total++;
        if ({meas_id, meas_width, meas_timeout, near} !== e) begin
          bad++;
          $display("FAIL result: got id=%0d width=%0d tmo=%0b near=%b want id=%0d width=%0d tmo=%0b near=%b",
                   meas_id, meas_width, meas_timeout, near, e[29:27], e[26:5], e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    int k;
    bit seen;
    total = 0; bad = 0;
    rst_n = 1'b0; enable = 1'b0; echo = 4'b0;
    repeat (3) @(negedge clk);
    chk("rst_trigger", 32'(trigger), 32'd0);
    chk("rst_outputs", 32'({meas_valid, meas_id, meas_width, meas_timeout}), 32'd0);
    chk("rst_near_busy", 32'({near, busy}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_enable", 32'({trigger, busy}), 32'd0);
    enable = 1'b1;

    run_meas(0, 5, 30, 0, 30, 1'b0, 4'b0001);
    run_meas(1, 5, 30, 0, 30, 1'b0, 4'b0011);
    run_meas(2, 5, 30, 0, 30, 1'b0, 4'b0111);
    run_meas(3, 5, 30, 0, 30, 1'b0, 4'b1111);
    run_meas(0, 5, 30, 0, 30, 1'b0, 4'b1111);
    run_meas(1, 5, 60, 0, 60, 1'b0, 4'b1101);
    run_meas(2, 0, 0, 2, 100, 1'b1, 4'b1001);
    run_meas(3, 5, 150, 0, 100, 1'b1, 4'b0001);
    run_meas(0, 5, 30, 0, 30, 1'b0, 4'b0001);
    run_meas(1, 5, 20, 1, 20, 1'b0, 4'b0011);
    run_meas(2, 5, 30, 3, 30, 1'b0, 4'b0111);

    // enable was dropped mid-measurement: expect result, guard, then IDLE
    k = 0;
    while (busy && k < 300) begin @(negedge clk); k++; end
    chk("idle_after_drop_busy", 32'(busy), 32'd0);
    chk("idle_after_drop_state", 32'(state_dbg), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (trigger != 4'b0 || busy || meas_valid) seen = 1'b1;
    end
    chk("idle_quiet", 32'(seen), 32'd0);

    // re-enable: pointer advanced to sensor 3; reset in the middle of TRIG
    enable = 1'b1;
    k = 0;
    while (trigger == 4'b0 && k < 50) begin @(negedge clk); k++; end
    chk("resume_sensor3", 32'(trigger), 32'b1000);
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_rst_trigger", 32'(trigger), 32'd0);
    chk("async_rst_outputs", 32'({meas_valid, meas_id, meas_width, meas_timeout}), 32'd0);
    chk("async_rst_near_busy", 32'({near, busy}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (trigger != 4'b0 || busy || meas_valid || near != 4'b0) seen = 1'b1;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);

    enable = 1'b1;
    run_meas(0, 5, 30, 0, 30, 1'b0, 4'b0001);
    enable = 1'b0;

    k = 0;
    while (exp_q.size() != 0 && k < 300) begin @(negedge clk); k++; end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
